// File: rtl/instr_mem_pipe.sv
// Synchronous instruction store with valid/ready fetch and response channels,
// a READ_LATENCY-deep read pipeline and a program-load port. Optional parity: INSTR_MEM_PARITY_EN.
module instr_mem_pipe #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INSTR_WIDTH  = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INSTR_WIDTH-1:0]   rsp_instr,
    output logic                     rsp_fault,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [INSTR_WIDTH-1:0]   load_data,
    output logic                     busy
`ifdef INSTR_MEM_PARITY_EN
    ,
    output logic                     rsp_perr,
    output logic                     perr_sticky
`endif
);

    localparam int AW  = $clog2(DEPTH);
    localparam int ALB = $clog2(INSTR_WIDTH / 8);
`ifdef INSTR_MEM_PARITY_EN
    localparam int MW  = INSTR_WIDTH + 1;
`else
    localparam int MW  = INSTR_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] AL_MASK = ADDR_WIDTH'((1 << ALB) - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [MW-1:0] mem [DEPTH];

    logic                   stall;
    logic                   accept;
    logic                   fault;
    logic                   load_ok;
    logic [ADDR_WIDTH-1:0]  word_idx;
    logic [MW-1:0]          rd_word;

    logic                   st_v     [READ_LATENCY];
    logic [INSTR_WIDTH-1:0] st_instr [READ_LATENCY];
    logic                   st_fault [READ_LATENCY];
`ifdef INSTR_MEM_PARITY_EN
    logic                   st_perr  [READ_LATENCY];
`endif

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers where rsp_valid && rsp_ready. An un-taken response freezes
    // every stage, and a load cycle refuses requests but never freezes the pipeline.
    assign rsp_valid = st_v[READ_LATENCY-1];
    assign rsp_instr = st_instr[READ_LATENCY-1];
    assign rsp_fault = st_fault[READ_LATENCY-1];
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall && !load_en;
    assign accept    = req_valid && req_ready;

    assign word_idx = req_addr >> ALB;
    assign fault    = ((req_addr & AL_MASK) != '0) || ({1'b0, word_idx} >= DEPTH_W);
    // Faulting fetches never touch the array and return a NOP.
    assign rd_word  = fault ? '0 : mem[word_idx[AW-1:0]];

    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign load_ok = 1'b1;
        end else begin : g_npow2
            assign load_ok = ({1'b0, load_addr} < (AW + 1)'(DEPTH));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
`ifdef INSTR_MEM_PARITY_EN
            mem[load_addr] <= {^load_data, load_data};
`else
            mem[load_addr] <= load_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                st_v[i]     <= 1'b0;
                st_instr[i] <= '0;
                st_fault[i] <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
                st_perr[i]  <= 1'b0;
`endif
            end
        end else if (!stall) begin
            st_v[0] <= accept;
            if (accept) begin
                st_instr[0] <= rd_word[INSTR_WIDTH-1:0];
                st_fault[0] <= fault;
`ifdef INSTR_MEM_PARITY_EN
                // Stored word carries even parity, so its full XOR is zero when intact.
                st_perr[0]  <= !fault && (^rd_word);
`endif
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                st_v[i]     <= st_v[i-1];
                st_instr[i] <= st_instr[i-1];
                st_fault[i] <= st_fault[i-1];
`ifdef INSTR_MEM_PARITY_EN
                st_perr[i]  <= st_perr[i-1];
`endif
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            busy = busy | st_v[i];
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    assign rsp_perr = st_perr[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_sticky <= 1'b0;
        end else if (rsp_valid && rsp_perr) begin
            perr_sticky <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench for instr_mem_pipe (READ_LATENCY=2, DEPTH=256): ordering, latency,
// faults, backpressure, load priority and reset with fetches in flight.
module tb_instr_mem_pipe;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 256;
    localparam int RL    = 2;
    localparam logic [IW-1:0] PROG [4] = '{32'h20080001, 32'h20090002, 32'h01095020, 32'h00000000};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [IW-1:0] rsp_instr;
    logic          rsp_fault;
    logic          load_en = 1'b0;
    logic [7:0]    load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic          busy;
`ifdef INSTR_MEM_PARITY_EN
    logic          rsp_perr;
    logic          perr_sticky;
`endif

    instr_mem_pipe #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .busy(busy)
`ifdef INSTR_MEM_PARITY_EN
        , .rsp_perr(rsp_perr), .perr_sticky(perr_sticky)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int fetch_to = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // scoreboard capture: a response is taken at the next edge when valid && ready
    logic [IW-1:0] exp_q [$];
    logic [IW-1:0] got_instr [$];
    logic          got_fault [$];
    int            got_cyc [$];
    int            acc_q [$];

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            got_instr.push_back(rsp_instr);
            got_fault.push_back(rsp_fault);
            got_cyc.push_back(cyc_cnt);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        got_instr.delete();
        got_fault.delete();
        got_cyc.delete();
        acc_q.delete();
    endtask

    task automatic load_word(input logic [7:0] a, input logic [IW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                acc_q.push_back(cyc_cnt);
            end
            step();
        end
        req_valid = 1'b0;
        if (!ok) fetch_to++;
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        for (int i = 0; i < 40 && got_instr.size() < n; i++) step();
        repeat (4) step();
        ok = (got_instr.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (rsp_instr !== '0) begin n_err++; $display("FAIL reset_rsp_instr got=%h exp=0", rsp_instr); end
        n_cmp++; if (rsp_fault !== 1'b0) begin n_err++; $display("FAIL reset_rsp_fault got=%b exp=0", rsp_fault); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) load_word(8'(i), PROG[i]);
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(PROG[i]);
            fetch(AW'(i * 4));
        end
        wait_rsp(4, ok);
        n_cmp++; if (got_instr.size() != 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", got_instr.size()); end
        for (int i = 0; i < 4 && i < got_instr.size() && i < acc_q.size(); i++) begin
            n_cmp++; if (got_instr[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, got_instr[i], exp_q[i]); end
            n_cmp++; if (got_fault[i] !== 1'b0) begin n_err++; $display("FAIL b2b_fault[%0d] got=%b exp=0", i, got_fault[i]); end
            n_cmp++; if (got_cyc[i] - acc_q[i] != RL) begin n_err++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, got_cyc[i] - acc_q[i], RL); end
            if (i > 0) begin
                n_cmp++; if (got_cyc[i] - got_cyc[i-1] != 1) begin n_err++; $display("FAIL b2b_rate[%0d] got=%0d exp=1", i, got_cyc[i] - got_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_fault();
        bit ok;
        load_word(8'd255, 32'hDEADBEEF);
        clear_sb();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hDEADBEEF);
        fetch(32'h6);
        fetch(32'h400);
        fetch(32'h3FC);
        wait_rsp(3, ok);
        n_cmp++; if (got_instr.size() != 3) begin n_err++; $display("FAIL fault_count got=%0d exp=3", got_instr.size()); end
        for (int i = 0; i < 3 && i < got_instr.size(); i++) begin
            n_cmp++; if (got_instr[i] !== exp_q[i]) begin n_err++; $display("FAIL fault_instr[%0d] got=%h exp=%h", i, got_instr[i], exp_q[i]); end
            n_cmp++; if (got_fault[i] !== (i < 2)) begin n_err++; $display("FAIL fault_flag[%0d] got=%b exp=%b", i, got_fault[i], i < 2); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        for (int i = 0; i < 6; i++) load_word(8'(8 + i), 32'hA0000000 + IW'(i));
        clear_sb();
        for (int i = 0; i < 6; i++) exp_q.push_back(32'hA0000000 + IW'(i));
        fork
            begin
                for (int j = 0; j < 6; j++) fetch(AW'(32'h20 + j * 4));
            end
            begin
                // third edge retires word 8; word 9 is presented when ready drops
                for (int k = 0; k < 3; k++) step();
                rsp_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, rsp_valid); end
                    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready[%0d] got=%b exp=0", k, req_ready); end
                    n_cmp++; if (rsp_instr !== 32'hA0000001) begin n_err++; $display("FAIL stall_hold[%0d] got=%h exp=a0000001", k, rsp_instr); end
                    step();
                end
                rsp_ready = 1'b1;
            end
        join
        wait_rsp(6, ok);
        n_cmp++; if (got_instr.size() != 6) begin n_err++; $display("FAIL stall_count got=%0d exp=6", got_instr.size()); end
        for (int i = 0; i < 6 && i < got_instr.size(); i++) begin
            n_cmp++; if (got_instr[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, got_instr[i], exp_q[i]); end
        end
    endtask

    task automatic test_load_priority();
        bit ok;
        clear_sb();
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h40;
        load_en   = 1'b1;
        load_addr = 8'd16;
        load_data = 32'h11111111;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL load_block0 got=%b exp=0", req_ready); end
        step();
        load_data = 32'hCAFEF00D;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL load_block1 got=%b exp=0", req_ready); end
        step();
        load_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL load_release got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        wait_rsp(1, ok);
        n_cmp++; if (got_instr.size() != 1) begin n_err++; $display("FAIL load_count got=%0d exp=1", got_instr.size()); end
        if (got_instr.size() > 0) begin
            n_cmp++; if (got_instr[0] !== 32'hCAFEF00D) begin n_err++; $display("FAIL load_data got=%h exp=cafef00d", got_instr[0]); end
        end
    endtask

    task automatic test_reset_inflight();
        bit ok;
        clear_sb();
        rsp_ready = 1'b1;
        fetch(32'h0);
        fetch(32'h4);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_inflight_valid got=%b exp=0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_inflight_busy got=%b exp=0", busy); end
        n_cmp++; if (rsp_instr !== '0) begin n_err++; $display("FAIL rst_inflight_instr got=%h exp=0", rsp_instr); end
        step();
        rst_n = 1'b1;
        repeat (6) step();
        n_cmp++; if (got_instr.size() != 0) begin n_err++; $display("FAIL rst_stale_rsp got=%0d exp=0", got_instr.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
        fetch(32'h8);
        fetch(32'h3FC);
        wait_rsp(2, ok);
        n_cmp++; if (got_instr.size() != 2) begin n_err++; $display("FAIL rst_retain_count got=%0d exp=2", got_instr.size()); end
        if (got_instr.size() > 1) begin
            n_cmp++; if (got_instr[0] !== 32'h01095020) begin n_err++; $display("FAIL rst_retain0 got=%h exp=01095020", got_instr[0]); end
            n_cmp++; if (got_instr[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rst_retain1 got=%h exp=deadbeef", got_instr[1]); end
        end
    endtask

`ifdef INSTR_MEM_PARITY_EN
    task automatic test_parity();
        bit seen;
        seen = 1'b0;
        load_word(8'd5, 32'h12345678);
        dut.mem[5][0] = ~dut.mem[5][0];
        clear_sb();
        req_valid = 1'b1;
        req_addr  = 32'h14;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                n_cmp++; if (rsp_perr !== 1'b1) begin n_err++; $display("FAIL perr_flag got=%b exp=1", rsp_perr); end
            end
            step();
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL perr_rsp got=none exp=response"); end
        repeat (3) step();
        n_cmp++; if (perr_sticky !== 1'b1) begin n_err++; $display("FAIL perr_sticky got=%b exp=1", perr_sticky); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (perr_sticky !== 1'b0) begin n_err++; $display("FAIL perr_sticky_rst got=%b exp=0", perr_sticky); end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_fault();
        test_stall();
        test_load_priority();
        test_reset_inflight();
`ifdef INSTR_MEM_PARITY_EN
        test_parity();
`endif
        n_cmp++; if (fetch_to != 0) begin n_err++; $display("FAIL fetch_accept got=%0d timeouts exp=0", fetch_to); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
